ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch engine between the program counter register and the
//  instruction memory port. Reads the current PC, issues word fetches, buffers
//  returned instructions for decode, and drives the PC's next-address input
//  (sequential +4 or branch/jump redirect).
// PARAMETERS
//  DEPTH     2            instruction buffer entries (power of two, >=2)
//  PC_STEP   32'h4        sequential increment added to the PC on each accepted fetch
// PORTS
//  I_clk            in   1   clock; all state updates on rising edge
//  I_rst            in   1   synchronous, active-high reset
//  I_pc             in   32  current PC (PC register output)
//  O_next_pc        out  32  next PC (PC register input); combinational
//  O_mem_req        out  1   fetch request; held until acknowledged
//  O_mem_addr       out  32  word-aligned fetch address; stable while O_mem_req=1
//  I_mem_ack        in   1   one-cycle acknowledge; I_mem_rdata valid this cycle
//  I_mem_rdata      in   32  instruction word
//  O_instr_valid    out  1   buffer head valid toward decode
//  O_instr          out  32  buffer head instruction
//  O_instr_pc       out  32  PC of buffer head instruction
//  I_instr_ready    in   1   decode accepts head when O_instr_valid=1
//  I_redirect       in   1   branch/jump taken; flush and refetch
//  I_redirect_pc    in   32  redirect target
// BEHAVIOUR
//  Reset: state=IDLE, buffer empty, O_mem_req=0, O_instr_valid=0, O_instr=0, O_instr_pc=0.
//  FSM states:
//   IDLE    -> REQ next cycle unconditionally; absorbs the PC's reset cycle.
//   REQ     O_mem_req=1, O_mem_addr={I_pc[31:2],2'b00}. On ack: push {I_pc,rdata};
//           go to WAIT if buffer full after this cycle's push/pop, else stay in REQ.
//   WAIT    O_mem_req=0; -> REQ when registered count < DEPTH.
//   DISCARD O_mem_req=1 at latched addr_q (address of the abandoned fetch);
//           on ack, data dropped -> REQ.
//  Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle.
//  O_next_pc priority: I_redirect -> I_redirect_pc; else REQ&ack -> I_pc+PC_STEP;
//   else I_pc. I_pc[1:0] ignored on the bus; O_instr_pc carries I_pc unmodified.
//  Redirect (any state): buffer flushed same edge; head dropped even if
//   ready=1 that cycle. In REQ without ack -> DISCARD (bus request must not be
//   withdrawn). In REQ with ack -> data dropped, REQ at new PC. In WAIT/IDLE -> REQ.
//   In DISCARD: remain in DISCARD and PC updates to the newest target.
//  Buffer: push and pop in the same cycle are both performed, including when
//   full. Pop occurs only when valid&ready. No push occurs on a redirect cycle.
//  addr_q captures the fetch address every REQ cycle; it is used only in DISCARD.
//  Reset mid-fetch: outstanding request abandoned; memory shares I_rst and
//   must drop it. All state returns to reset values on the next edge.
// STRUCTURE
//  ifetch_pkg: state encoding (IDLE/REQ/WAIT/DISCARD, 2 bits), XLEN=32,
//   INSTR_NOP=32'h00000013, and the fetch-entry struct/width {pc,instr}=64.
//  ifetch_fifo: sub-module. Synchronous FIFO of DEPTH x 64 with push, pop,
//   and flush, plus full, empty, and count outputs. Flush has priority over push.
//  Top level: FSM, addr_q, and next-PC mux.
// TESTING
//  1 Reset held 3 cycles, RESET=0 -> O_mem_req=0 during reset; first
//    O_mem_req=1 with addr 0x0 in the 2nd cycle after release.
//  2 Zero-wait memory, ready=1 -> instr at PCs 0x0,0x4,0x8,0xC on consecutive
//    cycles; O_next_pc = I_pc+4 every cycle.
//  3 ready=0, zero-wait memory -> exactly 2 pushes (0x0,0x4), then
//    O_mem_req=0 (WAIT). ready=1 for 1 cycle -> 0x0 popped, REQ resumes at 0x8.
//  4 Ack delayed 3 cycles at 0x8 with redirect to 0x100 in cycle 1 ->
//    O_mem_addr stays 0x8 until ack, data dropped, buffer empty, next req 0x100.
//  5 Redirect to 0x200 on the same cycle as ack at 0x10 with 1 buffered
//    entry -> nothing pushed or emitted, O_next_pc=0x200, next req 0x200.
//  6 I_rst asserted while REQ waits for ack -> next cycle O_mem_req=0,
//    O_instr_valid=0, state IDLE; fetch restarts at the RESET PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, fetch-buffer entry
// layout and the bus address alignment helper.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO for fetched {pc, instr} entries. Flush beats push;
// a push into a full buffer is accepted when a pop happens in the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         I_clk,
  input  logic         I_rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;

  // Register storage keeps the head visible combinationally to decode.
  assign rdata = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge I_clk) begin
        if (I_rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge I_clk) begin
    if (I_rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch engine: issues word fetches at the current PC, buffers
// returned instructions for decode and steers the PC register's next value.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int               DEPTH   = 2,
  parameter logic [XLEN-1:0]  PC_STEP = 32'h4
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic [XLEN-1:0] I_pc,
  output logic [XLEN-1:0] O_next_pc,
  output logic            O_mem_req,
  output logic [XLEN-1:0] O_mem_addr,
  input  logic            I_mem_ack,
  input  logic [XLEN-1:0] I_mem_rdata,
  output logic            O_instr_valid,
  output logic [XLEN-1:0] O_instr,
  output logic [XLEN-1:0] O_instr_pc,
  input  logic            I_instr_ready,
  input  logic            I_redirect,
  input  logic [XLEN-1:0] I_redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e    state_reg;
  fetch_state_e    state_next;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] addr_next;

  logic            req_ack;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   count_after;
  logic            full_after;
  fetch_entry_t    head;
  fetch_entry_t    wentry;

  assign req_ack = (state_reg == ST_REQ) && I_mem_ack;
  assign push    = req_ack && !I_redirect;
  // A redirect drops the head even when decode is ready that cycle.
  assign pop     = O_instr_valid && I_instr_ready && !I_redirect;

  assign count_after = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign full_after  = (count_after == (CNT_W+1)'(DEPTH));

  assign wentry = '{pc: I_pc, instr: I_mem_rdata};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .flush (I_redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign O_instr_valid = !fifo_empty;
  assign O_instr       = head.instr;
  assign O_instr_pc    = head.pc;

  assign O_next_pc = I_redirect ? I_redirect_pc :
                     req_ack    ? (I_pc + PC_STEP) : I_pc;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    O_mem_req  = 1'b0;
    O_mem_addr = addr_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        O_mem_req  = 1'b1;
        O_mem_addr = word_align(I_pc);
        addr_next  = word_align(I_pc);
        // An unacknowledged request cannot be withdrawn, so it is drained in DISCARD.
        if (I_redirect) begin
          state_next = I_mem_ack ? ST_REQ : ST_DISCARD;
        end else if (I_mem_ack && full_after) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (I_redirect || !fifo_full) state_next = ST_REQ;
      end
      ST_DISCARD: begin
        O_mem_req = 1'b1;
        if (I_mem_ack) state_next = ST_REQ;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: owns the PC register and a latency-programmable memory,
// runs directed scenarios then randomized traffic against a stream scoreboard.
module tb_ifetch_unit;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int ack_cnt = 0;

  logic manual = 1'b0;
  logic man_ack = 1'b0;
  int   lat_fixed = 0;
  int   lat_cur = 0;
  int   wait_cnt = 0;

  logic [31:0] exp_q[$];

  always #5 I_clk = ~I_clk;

  ifetch_unit dut (
    .I_clk         (I_clk),
    .I_rst         (I_rst),
    .I_pc          (pc_q),
    .O_next_pc     (next_pc),
    .O_mem_req     (mem_req),
    .O_mem_addr    (mem_addr),
    .I_mem_ack     (mem_ack),
    .I_mem_rdata   (mem_rdata),
    .O_instr_valid (instr_valid),
    .O_instr       (instr),
    .O_instr_pc    (instr_pc),
    .I_instr_ready (ready),
    .I_redirect    (redirect),
    .I_redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {w[15:0], ~w[15:0]} ^ 32'h0000_0013;
  endfunction

  // PC register and memory model; memory shares reset and forgets its request.
  always @(posedge I_clk) pc_q <= I_rst ? 32'h0 : next_pc;

  assign mem_ack   = mem_req && (manual ? man_ack : (wait_cnt >= lat_cur));
  assign mem_rdata = mem_word(mem_addr);

  always @(posedge I_clk) begin
    if (I_rst || mem_ack || !mem_req) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mem_ack) lat_cur <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    if (I_rst) ack_cnt <= 0;
    else if (mem_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge I_clk);
    #1;
  endtask

  task automatic wait_req(input string name, input int max_cyc);
    int n = 0;
    while (!mem_req && n < max_cyc) begin
      cyc();
      n++;
    end
    checks++;
    if (!mem_req) begin
      errors++;
      $display("FAIL %s: no fetch request within %0d cycles", name, max_cyc);
    end
  endtask

  // Scoreboard: decode must see consecutive PCs from the last reset/redirect target.
  initial begin : monitor
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] e;
    forever begin
      @(negedge I_clk);
      if (pend) begin
        check("req_held", {31'b0, mem_req}, 32'h1);
        check("addr_stable", mem_addr, pend_addr);
      end
      if (mem_req) check("addr_aligned", {30'b0, mem_addr[1:0]}, 32'h0);
      pend      = !I_rst && mem_req && !mem_ack;
      pend_addr = mem_addr;
      if (I_rst) begin
        exp_q.delete();
        exp_q.push_back(32'h0);
      end else if (redirect) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end else if (instr_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream: unexpected instruction pc=%h", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr", instr, mem_word(e));
          exp_q.push_back(e + 32'h4);
          accepts++;
          $display("accept pc=%h instr=%h", instr_pc, instr);
        end
      end
    end
  end

  initial begin
    int acc_start;
    I_rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset held three cycles, then zero-wait streaming
    cyc();
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    cyc(); cyc();
    I_rst = 1'b0; ready = 1'b1; #1;
    check("t1_idle_req", {31'b0, mem_req}, 32'h0);
    cyc();
    check("t1_first_req", {31'b0, mem_req}, 32'h1);
    check("t1_first_addr", mem_addr, 32'h0);
    check("t2_next_pc0", next_pc, 32'h4);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t2_valid", {31'b0, instr_valid}, 32'h1);
      check("t2_head_pc", instr_pc, 32'(4 * k));
      check("t2_next_pc", next_pc, pc_q + 32'h4);
    end

    // Redirect coinciding with an ack while one entry is buffered
    cyc();
    check("t5_head_pc", instr_pc, 32'hC);
    check("t5_addr", mem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h200; #1;
    check("t5_ack", {31'b0, mem_ack}, 32'h1);
    check("t5_next_pc", next_pc, 32'h200);
    cyc();
    redirect = 1'b0; #1;
    check("t5_valid", {31'b0, instr_valid}, 32'h0);
    check("t5_req", {31'b0, mem_req}, 32'h1);
    check("t5_addr_new", mem_addr, 32'h200);
    repeat (4) cyc();

    // Backpressure with zero-wait memory fills the buffer then waits
    I_rst = 1'b1; ready = 1'b0;
    cyc(); cyc();
    I_rst = 1'b0;
    repeat (5) cyc();
    check("t3_pushes", ack_cnt, 32'd2);
    check("t3_wait_req", {31'b0, mem_req}, 32'h0);
    check("t3_head_pc", instr_pc, 32'h0);
    check("t3_pc", pc_q, 32'h8);
    manual = 1'b1; man_ack = 1'b0; ready = 1'b1;
    cyc();
    ready = 1'b0; #1;
    check("t3_after_pop", instr_pc, 32'h4);
    wait_req("t3_resume", 8);
    check("t3_resume_addr", mem_addr, 32'h8);

    // Redirect during a slow fetch: request drained at the old address
    cyc();
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    check("t4_c1_addr", mem_addr, 32'h8);
    check("t4_next_pc", next_pc, 32'h100);
    cyc();
    redirect = 1'b0; #1;
    check("t4_c2_req", {31'b0, mem_req}, 32'h1);
    check("t4_c2_addr", mem_addr, 32'h8);
    check("t4_c2_valid", {31'b0, instr_valid}, 32'h0);
    check("t4_c2_pc", pc_q, 32'h100);
    cyc();
    man_ack = 1'b1; #1;
    check("t4_c3_addr", mem_addr, 32'h8);
    cyc();
    man_ack = 1'b0; #1;
    check("t4_c4_valid", {31'b0, instr_valid}, 32'h0);
    check("t4_c4_addr", mem_addr, 32'h100);

    // Reset while a request is outstanding
    man_ack = 1'b1;
    cyc();
    man_ack = 1'b0; #1;
    check("t6_valid_pre", {31'b0, instr_valid}, 32'h1);
    check("t6_addr_pre", mem_addr, 32'h104);
    I_rst = 1'b1;
    cyc();
    I_rst = 1'b0; #1;
    check("t6_req", {31'b0, mem_req}, 32'h0);
    check("t6_valid", {31'b0, instr_valid}, 32'h0);
    check("t6_instr", instr, 32'h0);
    check("t6_instr_pc", instr_pc, 32'h0);
    cyc();
    check("t6_restart_req", {31'b0, mem_req}, 32'h1);
    check("t6_restart_addr", mem_addr, 32'h0);

    // Randomized traffic
    manual = 1'b0; lat_fixed = -1;
    acc_start = accepts;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = {16'h0, 16'($urandom_range(0, 16'hFFFF))};
      I_rst       = ($urandom_range(0, 599) == 0);
    end
    cyc();
    redirect = 1'b0; I_rst = 1'b0; ready = 1'b1;
    repeat (10) cyc();
    checks++;
    if (accepts - acc_start < 300) begin
      errors++;
      $display("FAIL random_progress: got %0d accepted, required at least 300", accepts - acc_start);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
